// File: rtl/iiitb_usr_pkg.sv
// Shared state encoding and line levels for the serial frame transmitter.
package iiitb_usr_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/iiitb_baud_tick.sv
// Bit-period timer: tick marks the last clock of each CLKS_PER_BIT period while run is high.
// pre_tick says the next cycle will tick, letting the caller register tick-aligned outputs.
module iiitb_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic clear,
  input  logic run,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign tick      = run && (r_cnt == LAST);
  assign w_cnt_nxt = (!run || tick) ? '0 : r_cnt + 1'b1;
  assign pre_tick  = (w_cnt_nxt == LAST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

endmodule

// File: rtl/iiitb_usr_ser_tx.sv
// Serial frame transmitter: start, DATA_W bits LSB first, optional even parity, stop; one word per frame.
// in_ready only while idle; even parity bit enabled by defining IIITB_USR_SER_TX_PARITY_EN.
module iiitb_usr_ser_tx
  import iiitb_usr_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_serial,
  output logic              busy,
  output logic              frame_done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_tx;
  logic              r_busy;
  logic              r_ready;
  logic              r_done;
  logic              w_run;
  logic              w_tick;
  logic              w_pre_tick;
`ifdef IIITB_USR_SER_TX_PARITY_EN
  logic              r_parity;
`endif

  assign w_run       = (r_state != IDLE);
  assign w_shift_nxt = r_shift >> 1;

  iiitb_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock    (clock),
    .clear    (clear),
    .run      (w_run),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= LINE_IDLE;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
`ifdef IIITB_USR_SER_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (in_valid) begin
          r_shift   <= data_in;
          r_bit_cnt <= '0;
`ifdef IIITB_USR_SER_TX_PARITY_EN
          r_parity  <= ^data_in;
`endif
          r_state   <= START;
          r_tx      <= START_BIT;
          r_busy    <= 1'b1;
          r_ready   <= 1'b0;
        end
        START: if (w_tick) begin
          r_state <= DATA;
          r_tx    <= r_shift[0];
        end
        DATA: if (w_tick) begin
          if (r_bit_cnt == LAST_BIT) begin
`ifdef IIITB_USR_SER_TX_PARITY_EN
            r_state <= PARITY;
            r_tx    <= r_parity;
`else
            r_state <= STOP;
            r_tx    <= STOP_BIT;
            r_done  <= w_pre_tick;
`endif
          end else begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_tx      <= w_shift_nxt[0];
          end
        end
`ifdef IIITB_USR_SER_TX_PARITY_EN
        PARITY: if (w_tick) begin
          r_state <= STOP;
          r_tx    <= STOP_BIT;
          r_done  <= w_pre_tick;
        end
`endif
        // frame_done is registered, so it is raised one cycle ahead of the final stop clock
        STOP: if (w_tick) begin
          r_state <= IDLE;
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end else begin
          r_done  <= w_pre_tick;
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_ready;
  assign tx_serial  = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_iiitb_usr_ser_tx.sv
// Bench for iiitb_usr_ser_tx, instance 0 at CLKS_PER_BIT=4 and instance 1 at CLKS_PER_BIT=1.
module tb_iiitb_usr_ser_tx;

  localparam int NI = 2;
`ifdef IIITB_USR_SER_TX_PARITY_EN
  localparam int NB      = 11;
  localparam int A5_LIT  = 'hD4A;
  localparam int M81_LIT = 'hD02;
`else
  localparam int NB      = 10;
  localparam int A5_LIT  = 'h74A;
  localparam int M81_LIT = 'h702;
`endif
  localparam int MASK = (1 << (NB + 1)) - 1;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [7:0]    din [NI];
  logic [NI-1:0] vld = '0;
  logic [NI-1:0] rdy;
  logic [NI-1:0] txs;
  logic [NI-1:0] bsy;
  logic [NI-1:0] fd;
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  bit            chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cpb(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int C = (g == 0) ? 4 : 1;
    // expected {tx_serial, busy, frame_done, in_ready} for each upcoming cycle; empty means idle
    logic [3:0] exp_q [$];

    iiitb_usr_ser_tx #(.DATA_W(8), .CLKS_PER_BIT(C)) u_dut (
      .clock      (clk),
      .clear      (clr),
      .data_in    (din[g]),
      .in_valid   (vld[g]),
      .in_ready   (rdy[g]),
      .tx_serial  (txs[g]),
      .busy       (bsy[g]),
      .frame_done (fd[g])
    );

    always @(posedge clk or posedge clr) begin
      if (clr) exp_q.delete();
      else if (exp_q.size() != 0) void'(exp_q.pop_front());
      else if (vld[g]) begin
        for (int b = 0; b < NB; b++) begin
          logic lv;
          if (b == 0)                   lv = 1'b0;
          else if (b <= 8)              lv = din[g][b-1];
          else if (b == 9 && NB == 11)  lv = ^din[g];
          else                          lv = 1'b1;
          for (int c = 0; c < C; c++)
            exp_q.push_back({lv, 1'b1, (b == NB - 1 && c == C - 1), 1'b0});
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        logic [3:0] e;
        e = (exp_q.size() == 0) ? 4'b1001 : exp_q[0];
        vectors++;
        if ({txs[g], bsy[g], fd[g], rdy[g]} !== e) begin
          miscompares++;
          $display("FAIL cycle_%0d inst%0d {tx,busy,done,rdy}: got %b expected %b",
                   cyc, g, {txs[g], bsy[g], fd[g], rdy[g]}, e);
        end
      end
    end
  end

  task automatic accept(input int g, input logic [7:0] d, input bit keep, output int t);
    int n = 0;
    @(negedge clk);
    din[g] = d;
    vld[g] = 1'b1;
    while (!rdy[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", int'(rdy[g]), 1);
    @(posedge clk);
    #1;
    t = cyc;
    if (!keep) vld[g] = 1'b0;
  endtask

  task automatic watch(input int g, input int n, output logic [15:0] bits,
                       output int fd_at, output int busy_n);
    bits = '1;
    fd_at = 0;
    busy_n = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if ((k - 1) % cpb(g) == 0 && (k - 1) / cpb(g) < 16) bits[(k - 1) / cpb(g)] = txs[g];
      if (fd[g] && fd_at == 0) fd_at = k;
      if (bsy[g]) busy_n++;
    end
  endtask

  initial begin
    int t0, t1, fd_at, st2, busy_n;
    logic [15:0] bits;
    din[0] = 8'h00;
    din[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(txs), 3);
    check("rst_ready", int'(rdy), 3);
    check("rst_busy", int'(bsy), 0);
    check("rst_done", int'(fd), 0);
    #2 clr = 1'b0;
    chk_en = 1'b1;

    accept(0, 8'hA5, 1'b0, t0);
    watch(0, NB * 4 + 1, bits, fd_at, busy_n);
    check("a5_bits", int'(bits) & MASK, A5_LIT);
    check("a5_done_cycle", fd_at, NB * 4);
    check("a5_busy_cycles", busy_n, NB * 4);

    accept(0, 8'h00, 1'b0, t0);
    repeat (12) @(negedge clk);
    din[0] = 8'hFF;
    vld[0] = 1'b1;
    accept(0, 8'hFF, 1'b0, t1);
    check("busy_ignore_gap", t1 - t0, NB * 4 + 1);

    accept(0, 8'h3C, 1'b1, t0);
    din[0] = 8'hC3;
    fd_at = 0;
    st2 = 0;
    for (int k = 1; k <= 3 * NB * 4 && st2 == 0; k++) begin
      @(negedge clk);
      if (fd[0] && fd_at == 0) fd_at = k;
      else if (fd_at != 0 && bsy[0] && !txs[0]) st2 = k;
    end
    vld[0] = 1'b0;
    check("b2b_start_gap", st2 - fd_at, 2);

    accept(1, 8'h81, 1'b0, t0);
    watch(1, NB + 1, bits, fd_at, busy_n);
    check("m81_bits", int'(bits) & MASK, M81_LIT);
    check("m81_done_cycle", fd_at, NB);
    check("m81_busy_cycles", busy_n, NB);

`ifdef IIITB_USR_SER_TX_PARITY_EN
    accept(1, 8'h07, 1'b0, t0);
    watch(1, NB + 1, bits, fd_at, busy_n);
    check("p07_parity", int'(bits[9]), 1);
    check("p07_len", fd_at, 11);
    accept(1, 8'h03, 1'b0, t0);
    watch(1, NB + 1, bits, fd_at, busy_n);
    check("p03_parity", int'(bits[9]), 0);
`endif

    accept(0, 8'h5A, 1'b0, t0);
    repeat (17) @(negedge clk);
    check("pre_clr_busy", int'(bsy[0]), 1);
    #2 clr = 1'b1;
    #1;
    check("clr_tx", int'(txs[0]), 1);
    check("clr_busy", int'(bsy[0]), 0);
    check("clr_ready", int'(rdy[0]), 1);
    check("clr_done", int'(fd[0]), 0);
    repeat (2) @(negedge clk);
    #2 clr = 1'b0;
    accept(0, 8'h96, 1'b0, t0);
    watch(0, NB * 4 + 1, bits, fd_at, busy_n);
    check("post_clr_done", fd_at, NB * 4);
    check("post_clr_data", int'(bits >> 1) & 'hFF, 'h96);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int j = 0; j < NI; j++) begin
        vld[j] = ($urandom_range(0, 3) != 0);
        din[j] = 8'($urandom);
      end
      if (i == 750) begin
        #2 clr = 1'b1;
        @(negedge clk);
        #2 clr = 1'b0;
      end
    end
    vld = '0;
    repeat (NB * 4 + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
